// File: rtl/rv64g_l2_dir_update_if.sv
// Request, response and directory-array signals of the L2 directory update engine.
// The slave modport is the engine's view; the master modport is the requester/array side.
interface rv64g_l2_dir_update_if #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = 4
);
    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int CW = $clog2(CORES);

    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [2:0]                     req_op_i;
    logic [SW-1:0]                  req_set_i;
    logic [WW-1:0]                  req_way_i;
    logic [CW-1:0]                  req_core_i;

    logic [SW-1:0]                  dir_rd_set_o;
    logic [WAYS-1:0]                dir_rd_valid_i;
    logic [WAYS-1:0][CORES-1:0]     dir_rd_sharers_i;
    logic [WAYS-1:0]                dir_rd_owner_valid_i;
    logic [WAYS-1:0][CW-1:0]        dir_rd_owner_id_i;
    logic [WAYS-1:0]                dir_rd_dirty_i;

    logic                           dir_we_o;
    logic [SW-1:0]                  dir_wr_set_o;
    logic [WW-1:0]                  dir_wr_way_o;
    logic                           dir_wr_valid_o;
    logic [CORES-1:0]               dir_wr_sharers_o;
    logic                           dir_wr_owner_valid_o;
    logic [CW-1:0]                  dir_wr_owner_id_o;
    logic                           dir_wr_dirty_o;

    logic                           rsp_valid_o;
    logic                           rsp_ready_i;
    logic                           rsp_err_o;
    logic                           rsp_prev_valid_o;
    logic [CORES-1:0]               rsp_prev_sharers_o;
    logic                           rsp_prev_owner_valid_o;
    logic [CW-1:0]                  rsp_prev_owner_id_o;
    logic                           rsp_prev_dirty_o;

    modport slave (
        input  req_valid_i, req_op_i, req_set_i, req_way_i, req_core_i,
        output req_ready_o,
        output dir_rd_set_o,
        input  dir_rd_valid_i, dir_rd_sharers_i, dir_rd_owner_valid_i, dir_rd_owner_id_i,
        input  dir_rd_dirty_i,
        output dir_we_o, dir_wr_set_o, dir_wr_way_o, dir_wr_valid_o, dir_wr_sharers_o,
        output dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o,
        output rsp_valid_o, rsp_err_o, rsp_prev_valid_o, rsp_prev_sharers_o,
        output rsp_prev_owner_valid_o, rsp_prev_owner_id_o, rsp_prev_dirty_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_set_i, req_way_i, req_core_i,
        input  req_ready_o,
        input  dir_rd_set_o,
        output dir_rd_valid_i, dir_rd_sharers_i, dir_rd_owner_valid_i, dir_rd_owner_id_i,
        output dir_rd_dirty_i,
        input  dir_we_o, dir_wr_set_o, dir_wr_way_o, dir_wr_valid_o, dir_wr_sharers_o,
        input  dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o,
        input  rsp_valid_o, rsp_err_o, rsp_prev_valid_o, rsp_prev_sharers_o,
        input  rsp_prev_owner_valid_o, rsp_prev_owner_id_o, rsp_prev_dirty_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/rv64g_l2_dir_update.sv
// Read-modify-write engine for the L2 coherence directory: zero sweep after reset, then one update at a time.
// Optional statistics counters are enabled by defining L2_DIR_STATS_EN.
module rv64g_l2_dir_update #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rv64g_l2_dir_update_if.slave     bus,
    output logic                     init_done_o,
    output logic [31:0]              stat_updates_o,
    output logic [31:0]              stat_errs_o
);
    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int CW = $clog2(CORES);
    localparam int IW = SW + WW;
    localparam logic [IW-1:0] INIT_LAST = IW'(SETS * WAYS - 1);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;
    typedef enum logic [2:0] {
        OP_ALLOC, OP_ADD_SHARER, OP_SET_OWNER, OP_MARK_DIRTY,
        OP_DOWNGRADE, OP_REMOVE_CORE, OP_INVALIDATE, OP_LOOKUP
    } op_e;
    typedef struct packed {
        logic             valid;
        logic [CORES-1:0] sharers;
        logic             owner_valid;
        logic [CW-1:0]    owner_id;
        logic             dirty;
    } entry_t;

    state_e         state_q, state_d;
    logic [IW-1:0]  init_cnt_q, init_cnt_d;
    op_e            op_q, op_d;
    logic [SW-1:0]  set_q, set_d;
    logic [WW-1:0]  way_q, way_d;
    logic [CW-1:0]  core_q, core_d;
    entry_t         prev_q, prev_d;
    entry_t         new_entry, wr_entry;
    logic           err, no_write;
    logic [CORES-1:0] core_oh, owner_oh;

    // The directory array itself has no reset; the INIT sweep is what clears it.
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            op_q       <= OP_ALLOC;
            set_q      <= '0;
            way_q      <= '0;
            core_q     <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            op_q       <= op_d;
            set_q      <= set_d;
            way_q      <= way_d;
            core_q     <= core_d;
            prev_q     <= prev_d;
        end
    end

    // Recompute the entry from the registered previous value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        core_oh            = '0;
        core_oh[core_q]    = 1'b1;
        owner_oh           = '0;
        owner_oh[prev_q.owner_id] = 1'b1;
        new_entry          = prev_q;
        err                = 1'b0;
        no_write           = 1'b0;
        case (op_q)
            OP_ALLOC: begin
                new_entry       = '0;
                new_entry.valid = 1'b1;
            end
            OP_ADD_SHARER: begin
                new_entry         = '0;
                new_entry.valid   = 1'b1;
                new_entry.sharers = prev_q.sharers | core_oh;
            end
            OP_SET_OWNER: begin
                new_entry             = '0;
                new_entry.valid       = 1'b1;
                new_entry.owner_valid = 1'b1;
                new_entry.owner_id    = core_q;
            end
            OP_MARK_DIRTY: begin
                err             = !(prev_q.valid && prev_q.owner_valid && prev_q.owner_id == core_q);
                new_entry.dirty = 1'b1;
            end
            OP_DOWNGRADE: begin
                err                   = !prev_q.owner_valid;
                new_entry.sharers     = owner_oh;
                new_entry.owner_valid = 1'b0;
                new_entry.owner_id    = '0;
                new_entry.dirty       = 1'b0;
            end
            OP_REMOVE_CORE: begin
                new_entry.sharers = prev_q.sharers & ~core_oh;
                if (prev_q.owner_valid && prev_q.owner_id == core_q) begin
                    new_entry.owner_valid = 1'b0;
                    new_entry.owner_id    = '0;
                    new_entry.dirty       = 1'b0;
                end
            end
            OP_INVALIDATE: new_entry = '0;
            default:       no_write  = 1'b1;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        init_cnt_d       = init_cnt_q;
        op_d             = op_q;
        set_d            = set_q;
        way_d            = way_q;
        core_d           = core_q;
        prev_d           = prev_q;
        bus.req_ready_o  = 1'b0;
        bus.rsp_valid_o  = 1'b0;
        bus.dir_we_o     = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.dir_we_o = 1'b1;
                init_cnt_d   = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    op_d    = op_e'(bus.req_op_i);
                    set_d   = bus.req_set_i;
                    way_d   = bus.req_way_i;
                    core_d  = bus.req_core_i;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                prev_d.valid       = bus.dir_rd_valid_i[way_q];
                prev_d.sharers     = bus.dir_rd_sharers_i[way_q];
                prev_d.owner_valid = bus.dir_rd_owner_valid_i[way_q];
                prev_d.owner_id    = bus.dir_rd_owner_id_i[way_q];
                prev_d.dirty       = bus.dir_rd_dirty_i[way_q];
                state_d            = ST_WRITE;
            end
            ST_WRITE: begin
                bus.dir_we_o = !(err || no_write);
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign wr_entry                 = (state_q == ST_INIT) ? '0 : new_entry;
    assign bus.dir_rd_set_o         = set_q;
    assign bus.dir_wr_set_o         = (state_q == ST_INIT) ? init_cnt_q[IW-1:WW] : set_q;
    assign bus.dir_wr_way_o         = (state_q == ST_INIT) ? init_cnt_q[WW-1:0] : way_q;
    assign bus.dir_wr_valid_o       = wr_entry.valid;
    assign bus.dir_wr_sharers_o     = wr_entry.sharers;
    assign bus.dir_wr_owner_valid_o = wr_entry.owner_valid;
    assign bus.dir_wr_owner_id_o    = wr_entry.owner_id;
    assign bus.dir_wr_dirty_o       = wr_entry.dirty;

    assign bus.rsp_err_o              = bus.rsp_valid_o && err;
    assign bus.rsp_prev_valid_o       = prev_q.valid;
    assign bus.rsp_prev_sharers_o     = prev_q.sharers;
    assign bus.rsp_prev_owner_valid_o = prev_q.owner_valid;
    assign bus.rsp_prev_owner_id_o    = prev_q.owner_id;
    assign bus.rsp_prev_dirty_o       = prev_q.dirty;
    assign init_done_o                = (state_q != ST_INIT);

`ifdef L2_DIR_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d, stat_err_q, stat_err_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_err_d = stat_err_q;
        if (bus.dir_we_o && state_q != ST_INIT && stat_upd_q != '1)
            stat_upd_d = stat_upd_q + 1'b1;
        if (bus.rsp_err_o && bus.rsp_ready_i && stat_err_q != '1)
            stat_err_d = stat_err_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_upd_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_updates_o = stat_upd_q;
    assign stat_errs_o    = stat_err_q;
`else
    assign stat_updates_o = '0;
    assign stat_errs_o    = '0;
`endif
endmodule
